// File: rtl/hazard_ctrl_if.sv
// -----------------------------------------------------------------------------
// hazard_ctrl_if
// Bundles the hazard-detection inputs coming from the 5-stage datapath and the
// stall / flush / PC-enable controls going back to its pipeline registers.
//
// Handshake semantics (the only ones used here): ihit and dhit act as "ready"
// for the fetch and data accesses. A fetch is accepted in the cycle ihit = 1.
// A data access presented by dmem_req_exmem completes in the cycle dhit = 1.
// Until then the requesting stage and everything upstream of it are held.
//
// Modports
//   master : datapath side; drives the hazard inputs and receives the controls
//   slave  : hazard controller side; samples the inputs and drives the controls
//
// Signals
//   ihit, dhit            fetch / data access completes this cycle
//   dmem_req_exmem        EX/MEM holds a load or store
//   MemtoReg_idex         ID/EX holds a load
//   rt_idex               load destination register
//   rs_ifid, rt_ifid      IF/ID source registers
//   use_rt_ifid           IF/ID instruction reads rt
//   redirect              taken branch / jump / mispredict resolved
//   halt_memwb            halt instruction in MEM/WB
//   pc_en                 PC load enable
//   stall_* / flush_*     hold / bubble-load per pipeline register
// -----------------------------------------------------------------------------
interface hazard_ctrl_if #(
   parameter int REG_W = 5
);
   logic             ihit;
   logic             dhit;
   logic             dmem_req_exmem;
   logic             MemtoReg_idex;
   logic [REG_W-1:0] rt_idex;
   logic [REG_W-1:0] rs_ifid;
   logic [REG_W-1:0] rt_ifid;
   logic             use_rt_ifid;
   logic             redirect;
   logic             halt_memwb;

   logic             pc_en;
   logic             stall_ifid;
   logic             stall_idex;
   logic             stall_exmem;
   logic             stall_memwb;
   logic             flush_ifid;
   logic             flush_idex;
   logic             flush_exmem;
   logic             flush_memwb;

   modport master (
      output ihit, dhit, dmem_req_exmem, MemtoReg_idex, rt_idex, rs_ifid,
             rt_ifid, use_rt_ifid, redirect, halt_memwb,
      input  pc_en, stall_ifid, stall_idex, stall_exmem, stall_memwb,
             flush_ifid, flush_idex, flush_exmem, flush_memwb
   );

   modport slave (
      input  ihit, dhit, dmem_req_exmem, MemtoReg_idex, rt_idex, rs_ifid,
             rt_ifid, use_rt_ifid, redirect, halt_memwb,
      output pc_en, stall_ifid, stall_idex, stall_exmem, stall_memwb,
             flush_ifid, flush_idex, flush_exmem, flush_memwb
   );
endinterface

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
// Pipeline hazard controller for the 5-stage MIPS datapath. It produces the
// stall, flush and PC-enable controls for IF/ID, ID/EX, EX/MEM and MEM/WB. The
// controls are combinational from the inputs, the FSM state and the load-use
// countdown, so a hazard gets a zero-cycle response.
//
// Parameters
//   REG_W        register index width
//   LOAD_BUBBLES bubbles per load-use hazard (1..3)
//   BR_STAGE     stage that resolves redirect: 2 = EX, 3 = MEM
//   CNT_W        performance counter width
//
// Ports
//   CLK, RST        clock (rising edge), synchronous active-high reset
//   hz              hazard_ctrl_if.slave: datapath inputs and controls
//   state           FSM state (RUN=0, LU_STALL=1, REDIR_PEND=2, HALTED=3)
//   lu_stall_cnt    load-use stall cycles
//   mem_stall_cnt   data-miss wait cycles
//   flush_cnt       redirect cycles
//
// Build option
//   HAZARD_PERF_CNT_EN  when defined, builds the saturating performance
//                       counters. Otherwise the counter ports read 0.
// -----------------------------------------------------------------------------
module hazard_ctrl #(
   parameter int REG_W        = 5,
   parameter int LOAD_BUBBLES = 1,
   parameter int BR_STAGE     = 2,
   parameter int CNT_W        = 32
) (
   input  logic             CLK,
   input  logic             RST,
   hazard_ctrl_if.slave     hz,
   output logic [1:0]       state,
   output logic [CNT_W-1:0] lu_stall_cnt,
   output logic [CNT_W-1:0] mem_stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   typedef enum logic [1:0] {
      ST_RUN        = 2'd0,
      ST_LU_STALL   = 2'd1,
      ST_REDIR_PEND = 2'd2,
      ST_HALTED     = 2'd3
   } state_t;

   localparam logic [REG_W-1:0] REG_ZERO     = '0;
   localparam logic [1:0]       LU_INIT      = 2'(LOAD_BUBBLES - 1);
   localparam bit               MULTI_BUBBLE = (LOAD_BUBBLES > 1);
   // With a MEM-stage branch, the wrong-path instruction in EX/MEM also dies.
   localparam bit               FLUSH_EXMEM  = (BR_STAGE == 3);

   state_t     state_q, state_n;
   logic [1:0] lu_cnt_q, lu_cnt_n;

   logic is_halt;
   logic memwait;
   logic loaduse;
   logic below_redir;
   logic br_mem;
   logic br_redir;
   logic br_pend;
   logic br_lu;
   logic br_loaduse;
   logic br_miss;

   // One-hot decode of the prioritised condition that owns this cycle.
   assign is_halt     = (state_q == ST_HALTED) || hz.halt_memwb;
   assign memwait     = hz.dmem_req_exmem && !hz.dhit;
   assign loaduse     = (state_q == ST_RUN) && hz.MemtoReg_idex &&
                        (hz.rt_idex != REG_ZERO) &&
                        ((hz.rt_idex == hz.rs_ifid) ||
                         (hz.use_rt_ifid && (hz.rt_idex == hz.rt_ifid)));
   assign br_mem      = !is_halt && memwait;
   assign br_redir    = !is_halt && !memwait && hz.redirect;
   assign below_redir = !is_halt && !memwait && !hz.redirect;
   assign br_pend     = below_redir && (state_q == ST_REDIR_PEND);
   assign br_lu       = below_redir && (state_q == ST_LU_STALL);
   assign br_loaduse  = below_redir && loaduse;
   assign br_miss     = below_redir && (state_q == ST_RUN) && !loaduse && !hz.ihit;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q  <= ST_RUN;
         lu_cnt_q <= 2'd0;
      end else begin
         state_q  <= state_n;
         lu_cnt_q <= lu_cnt_n;
      end
   end

   always_comb begin
      hz.pc_en       = 1'b0;
      hz.stall_ifid  = 1'b0;
      hz.stall_idex  = 1'b0;
      hz.stall_exmem = 1'b0;
      hz.stall_memwb = 1'b0;
      hz.flush_ifid  = 1'b0;
      hz.flush_idex  = 1'b0;
      hz.flush_exmem = 1'b0;
      hz.flush_memwb = 1'b0;
      state_n        = state_q;
      lu_cnt_n       = lu_cnt_q;

      if (RST) begin
         // Every register loads a bubble while reset is held.
         hz.flush_ifid  = 1'b1;
         hz.flush_idex  = 1'b1;
         hz.flush_exmem = 1'b1;
         hz.flush_memwb = 1'b1;
      end else if (is_halt) begin
         hz.stall_ifid  = 1'b1;
         hz.stall_idex  = 1'b1;
         hz.stall_exmem = 1'b1;
         hz.stall_memwb = 1'b1;
         state_n        = ST_HALTED;
      end else if (br_mem) begin
         // Freeze everything up to EX/MEM; MEM/WB gets a bubble. The redirect
         // source is frozen too, so it is seen again once the miss clears.
         hz.stall_ifid  = 1'b1;
         hz.stall_idex  = 1'b1;
         hz.stall_exmem = 1'b1;
         hz.flush_memwb = 1'b1;
      end else if (br_redir) begin
         hz.pc_en       = 1'b1;
         hz.flush_ifid  = 1'b1;
         hz.flush_idex  = 1'b1;
         hz.flush_exmem = FLUSH_EXMEM;
         lu_cnt_n       = 2'd0;
         state_n        = hz.ihit ? ST_RUN : ST_REDIR_PEND;
      end else if (br_pend) begin
         // The fetch in flight is from the old path: drop it when it lands.
         hz.flush_ifid  = 1'b1;
         if (hz.ihit) begin
            state_n = ST_RUN;
         end
      end else if (br_lu) begin
         hz.stall_ifid  = 1'b1;
         hz.flush_idex  = 1'b1;
         lu_cnt_n       = lu_cnt_q - 2'd1;
         if (lu_cnt_q == 2'd1) begin
            state_n = ST_RUN;
         end
      end else if (br_loaduse) begin
         hz.stall_ifid  = 1'b1;
         hz.flush_idex  = 1'b1;
         if (MULTI_BUBBLE) begin
            state_n  = ST_LU_STALL;
            lu_cnt_n = LU_INIT;
         end
      end else if (br_miss) begin
         hz.flush_ifid  = 1'b1;
      end else begin
         hz.pc_en       = 1'b1;
      end
   end

   assign state = state_q;

`ifdef HAZARD_PERF_CNT_EN
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [CNT_W-1:0] lu_q, mem_q, fl_q;

   always_ff @(posedge CLK) begin
      if (RST) begin
         lu_q  <= '0;
         mem_q <= '0;
         fl_q  <= '0;
      end else begin
         if ((br_lu || br_loaduse) && (lu_q != CNT_MAX)) begin
            lu_q <= lu_q + 1'b1;
         end
         if (br_mem && (mem_q != CNT_MAX)) begin
            mem_q <= mem_q + 1'b1;
         end
         if (br_redir && (fl_q != CNT_MAX)) begin
            fl_q <= fl_q + 1'b1;
         end
      end
   end

   assign lu_stall_cnt  = lu_q;
   assign mem_stall_cnt = mem_q;
   assign flush_cnt     = fl_q;
`else
   assign lu_stall_cnt  = '0;
   assign mem_stall_cnt = '0;
   assign flush_cnt     = '0;
`endif

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Parametrised pipeline hazard controller for the 5-stage MIPS datapath (IF/ID/EX/MEM/WB). It generates stall, flush and PC-enable controls for the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. Over the single-cycle combinational hazard logic it adds:
- a configurable multi-bubble load-use stall, held by a countdown;
- a configurable branch-resolution stage;
- a pending-redirect state that discards a stale in-flight fetch;
- a sticky halt.

## Interface
Parameters:
- REG_W, 5, register index width
- LOAD_BUBBLES, 1, bubbles inserted per load-use hazard (legal 1..3)
- BR_STAGE, 2, stage that asserts redirect: 2 = EX, 3 = MEM
- CNT_W, 32, performance counter width

Ports (reset is synchronous, active-high):
- CLK  in  1  clock, rising edge
- RST  in  1  synchronous reset
- ihit  in  1  instruction fetch completes this cycle
- dhit  in  1  data access completes this cycle
- dmem_req_exmem  in  1  EX/MEM holds a load or store
- MemtoReg_idex  in  1  ID/EX holds a load
- rt_idex  in  REG_W  load destination register
- rs_ifid, rt_ifid  in  REG_W  source registers of the IF/ID instruction
- use_rt_ifid  in  1  IF/ID instruction reads rt
- redirect  in  1  taken branch, jump or mispredict resolved at BR_STAGE
- halt_memwb  in  1  halt instruction in MEM/WB
- pc_en  out  1  PC register load enable
- stall_ifid, stall_idex, stall_exmem, stall_memwb  out  1 each  hold register
- flush_ifid, flush_idex, flush_exmem, flush_memwb  out  1 each  load bubble
- state  out  2  FSM state, for debug
- lu_stall_cnt, mem_stall_cnt, flush_cnt  out  CNT_W each  performance counters

## Operation
FSM states: RUN=0, LU_STALL=1, REDIR_PEND=2, HALTED=3. A countdown register lu_cnt is 2 bits wide.

Conditions, evaluated in priority order:
1. **HALTED** (state HALTED, or halt_memwb)
   - All stalls = 1, pc_en = 0, no flush.
   - Next state is HALTED; only RST leaves it.
2. **memwait** (dmem_req_exmem && !dhit)
   - pc_en = 0; stall_ifid, stall_idex and stall_exmem = 1; flush_memwb = 1.
   - state and lu_cnt are frozen.
   - redirect is ignored; its source stays frozen, so it is re-sampled once memwait ends.
3. **redirect**
   - pc_en = 1; flush_ifid = 1; flush_idex = 1; flush_exmem = 1 only when BR_STAGE = 3.
   - Cancels LU_STALL: lu_cnt is cleared.
   - Next state is REDIR_PEND if ihit = 0, else RUN.
4. **REDIR_PEND**
   - flush_ifid = 1, pc_en = 0.
   - On ihit, the stale fetch is discarded and the state goes to RUN.
5. **LU_STALL**
   - pc_en = 0, stall_ifid = 1, flush_idex = 1.
   - lu_cnt decrements each cycle; when lu_cnt = 1, the next state is RUN.
6. **loaduse** (RUN and MemtoReg_idex and rt_idex != 0 and (rt_idex == rs_ifid or (use_rt_ifid and rt_idex == rt_ifid)))
   - Same outputs as LU_STALL.
   - If LOAD_BUBBLES > 1: go to LU_STALL with lu_cnt = LOAD_BUBBLES-1.
7. **fetch miss** (!ihit in RUN)
   - pc_en = 0, flush_ifid = 1; downstream stages advance.
8. **otherwise**
   - pc_en = 1; all stalls and flushes = 0.

Rules:
- stall and flush are never both 1 on the same register.
- Register index 0 never creates a hazard.

## Timing
- All control outputs are combinational from the inputs, state and lu_cnt. There is zero-cycle response to a hazard.
- state, lu_cnt and the counters update on the rising edge of CLK.
- While RST = 1:
  - pc_en = 0; all stalls = 0; all flushes = 1.
  - state becomes RUN, lu_cnt 0, counters 0 at the next edge.
- RST mid-stall or mid-halt returns the block to RUN in one cycle.
- A load-use hazard costs exactly LOAD_BUBBLES cycles of pc_en = 0 when no memwait or redirect intervenes.
  - memwait cycles extend the stall without consuming lu_cnt.
- A redirect costs 2 bubbles for BR_STAGE = 2 and 3 bubbles for BR_STAGE = 3, plus any REDIR_PEND cycles.

## Configuration
- HAZARD_PERF_CNT_EN defined:
  - lu_stall_cnt increments on every loaduse or LU_STALL cycle.
  - mem_stall_cnt increments on every memwait cycle.
  - flush_cnt increments on every redirect cycle.
  - All three saturate at all-ones and clear on RST.
- HAZARD_PERF_CNT_EN not defined: the counter ports remain and are tied to 0; no counter flops are built.

## Test plan
- **Load-use, 2 bubbles.** LOAD_BUBBLES = 2, rt_idex = 8, rs_ifid = 8, ihit = dhit = 1.
  - pc_en = 0 and flush_idex = 1 for exactly 2 cycles; state goes 0 -> 1 -> 0.
- **Redirect at MEM with miss.** BR_STAGE = 3, redirect = 1 while ihit = 0.
  - flush_ifid, flush_idex and flush_exmem = 1 for that cycle.
  - Next cycle state = 2 with pc_en = 0 until ihit, then state = 0.
- **Data miss over load-use.** dhit = 0 for 3 cycles during LU_STALL.
  - stall_exmem = 1 and flush_memwb = 1 for those 3 cycles; lu_cnt is unchanged; the stall resumes after.
- **Redirect during LU_STALL.** redirect = 1 while in LU_STALL.
  - lu_cnt cleared; state = 0 next cycle; pc_en = 1 on the redirect cycle.
- **Halt.** halt_memwb = 1, then deassert.
  - All stalls stay 1 and state = 3 until RST = 1; after reset, state = 0 and outputs are normal.
- **Counters.** With HAZARD_PERF_CNT_EN, run 1 load-use (LOAD_BUBBLES = 1), 4 memwait cycles and 2 redirects.
  - Counters read 1, 4, 2; without the macro they read 0.
